// File: rtl/irq_pending_arbiter_pkg.sv
// Shared definitions for the 16-input priority encode path.
// Holds the default request count / index width and the arbiter FSM encoding.
package irq_pending_arbiter_pkg;

  localparam int unsigned DEF_N_REQ = 16;
  localparam int unsigned DEF_IDX_W = 4;   // must equal $clog2(DEF_N_REQ)

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

endpackage

// File: rtl/irq_pending_arbiter_pending_select.sv
// Highest-index encoder: returns the index of the most significant set bit
// of vec, plus a flag telling whether any bit is set. Purely combinational.
//   vec       : input  N_REQ  candidate vector
//   sel_idx_c : output IDX_W  index of highest set bit (0 when none set)
//   sel_any_c : output 1      at least one bit of vec is set
module irq_pending_arbiter_pending_select #(
  parameter int unsigned N_REQ = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] sel_idx_c,
  output logic             sel_any_c
);

  // Ascending scan: the last hit wins, so the highest index has priority.
  always_comb begin
    sel_idx_c = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (vec[i]) begin
        sel_idx_c = IDX_W'(i);
      end
    end
  end

  assign sel_any_c = |vec;

endmodule

// File: rtl/irq_pending_arbiter.sv
// Sticky pending-request arbiter.
// Captures rising edges on req_in into a pending register, offers the
// highest-index unmasked pending request downstream over valid/ready, and
// clears that pending bit on acceptance.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : allows a new offer to start (capture is unaffected)
//   req_in       : level request lines
//   mask         : 1 = line not eligible for grant (still captured)
//   grant_valid  : offer of grant_idx
//   grant_ready  : downstream accepts the offer
//   grant_idx    : index being offered
//   pending      : sticky pending register
//   overflow     : one-cycle pulse, an edge hit an already-pending line
module irq_pending_arbiter
  import irq_pending_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  output logic             grant_valid,
  input  logic             grant_ready,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] grant_idx_n;
  logic [N_REQ-1:0] req_d;
  logic [N_REQ-1:0] edge_v;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pending_n;
  logic             overflow_n;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

  assign edge_v = req_in & ~req_d;
  assign elig   = pending & ~mask;

  // grant_valid is a direct decode of the state flop, so it drops with rst.
  assign grant_valid = (state == OFFER);

  irq_pending_arbiter_pending_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pending_select (
    .vec       (elig),
    .sel_idx_c (sel_idx),
    .sel_any_c (sel_any)
  );

  // Next-state, offer index, pending and overflow update.
  always_comb begin
    state_n     = state;
    grant_idx_n = grant_idx;
    clr         = '0;
    case (state)
      IDLE: begin
        if (enable && sel_any) begin
          state_n     = OFFER;
          grant_idx_n = sel_idx;
        end
      end
      OFFER: begin
        // Offer is held until accepted regardless of enable/mask/new requests.
        if (grant_ready) begin
          clr     = N_REQ'(1) << grant_idx;
          state_n = IDLE;
        end
      end
    endcase
    // A new edge re-sets a bit being cleared this cycle (set wins).
    pending_n  = (pending & ~clr) | edge_v;
    overflow_n = |(edge_v & pending & ~clr);
  end

  // State and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      req_d     <= '0;
      pending   <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      grant_idx <= grant_idx_n;
      req_d     <= req_in;
      pending   <= pending_n;
      overflow  <= overflow_n;
    end
  end

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Self-checking bench for irq_pending_arbiter: directed scenarios with
// constant expectations, then a randomized run against a behavioural model.
module tb_irq_pending_arbiter;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] req_in;
  logic [15:0] mask;
  logic        grant_valid;
  logic        grant_ready;
  logic [3:0]  grant_idx;
  logic [15:0] pending;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [15:0] m_pend;
  logic [15:0] m_prev;
  logic        m_valid;
  logic [3:0]  m_idx;
  logic        m_ovf;

  irq_pending_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req_in      (req_in),
    .mask        (mask),
    .grant_valid (grant_valid),
    .grant_ready (grant_ready),
    .grant_idx   (grant_idx),
    .pending     (pending),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend  = '0;
    m_prev  = '0;
    m_valid = 1'b0;
    m_idx   = '0;
    m_ovf   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic        fire;
    logic        ovf;
    logic [15:0] rise;
    logic [15:0] nxt;
    int          sel;
    fire = m_valid && grant_ready;
    rise = req_in & ~m_prev;
    ovf  = 1'b0;
    nxt  = m_pend;
    for (int i = 0; i < 16; i++) begin
      if (rise[i] && m_pend[i] && !(fire && (32'(m_idx) == i))) ovf = 1'b1;
    end
    if (fire) nxt[m_idx] = 1'b0;
    nxt = nxt | rise;
    if (m_valid) begin
      if (fire) m_valid = 1'b0;
    end else if (enable) begin
      sel = -1;
      for (int i = 0; i < 16; i++) begin
        if (m_pend[i] && !mask[i]) sel = i;
      end
      if (sel >= 0) begin
        m_valid = 1'b1;
        m_idx   = 4'(sel);
      end
    end
    m_pend = nxt;
    m_prev = req_in;
    m_ovf  = ovf;
  endtask

  // One clock: inputs were set by the caller; outputs sampled 1 ns after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; req_in = '0; mask = '0; grant_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", grant_valid); end
    total++; if (grant_idx !== 4'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", grant_idx); end
    total++; if (pending !== 16'h0) begin bad++; $display("FAIL reset_pending got=%h exp=0000", pending); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (grant_valid !== 1'b0 || pending !== 16'h0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet cyc=%0d got valid=%b pend=%h ovf=%b exp 0/0000/0", c, grant_valid, pending, overflow);
      end
    end
  endtask

  task automatic test_single();
    enable = 1'b1; grant_ready = 1'b1; mask = '0;
    req_in = 16'h0008;
    step();
    total++; if (pending !== 16'h0008 || grant_valid !== 1'b0) begin bad++; $display("FAIL single_capture got pend=%h valid=%b exp 0008/0", pending, grant_valid); end
    req_in = '0;
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd3) begin bad++; $display("FAIL single_offer got valid=%b idx=%0d exp 1/3", grant_valid, grant_idx); end
    step();
    total++; if (grant_valid !== 1'b0 || pending !== 16'h0) begin bad++; $display("FAIL single_accept got valid=%b pend=%h exp 0/0000", grant_valid, pending); end
  endtask

  task automatic test_multi();
    int exp_idx [4];
    int n;
    int last;
    exp_idx = '{15, 10, 5, 0};
    n = 0; last = -2;
    grant_ready = 1'b1; enable = 1'b1;
    req_in = 16'h8421;
    step();
    req_in = '0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (grant_valid) begin
        total++;
        if (n >= 4) begin
          bad++; $display("FAIL multi_extra got idx=%0d exp no offer", grant_idx);
        end else if (grant_idx !== 4'(exp_idx[n])) begin
          bad++; $display("FAIL multi_order n=%0d got=%0d exp=%0d", n, grant_idx, exp_idx[n]);
        end
        if (n > 0) begin
          total++;
          if (c - last != 2) begin bad++; $display("FAIL multi_spacing got=%0d exp=2", c - last); end
        end
        last = c;
        n++;
      end
    end
    total++; if (n != 4) begin bad++; $display("FAIL multi_count got=%0d exp=4", n); end
    total++; if (pending !== 16'h0) begin bad++; $display("FAIL multi_drain got=%h exp=0000", pending); end
  endtask

  task automatic test_hold();
    grant_ready = 1'b0; mask = '0; enable = 1'b1;
    req_in = 16'h0080;
    step();
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd7) begin bad++; $display("FAIL hold_offer7 got valid=%b idx=%0d exp 1/7", grant_valid, grant_idx); end
    req_in = 16'h1080;
    step();
    total++; if (grant_idx !== 4'd7 || pending !== 16'h1080) begin bad++; $display("FAIL hold_stable got idx=%0d pend=%h exp 7/1080", grant_idx, pending); end
    enable = 1'b0;
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd7) begin bad++; $display("FAIL hold_no_retract got valid=%b idx=%0d exp 1/7", grant_valid, grant_idx); end
    enable = 1'b1; mask = 16'h1000; grant_ready = 1'b1;
    step();
    total++; if (grant_valid !== 1'b0 || pending !== 16'h1000) begin bad++; $display("FAIL hold_accept7 got valid=%b pend=%h exp 0/1000", grant_valid, pending); end
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (grant_valid !== 1'b0 || pending !== 16'h1000) begin bad++; $display("FAIL hold_masked cyc=%0d got valid=%b pend=%h exp 0/1000", c, grant_valid, pending); end
    end
    mask = '0;
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd12) begin bad++; $display("FAIL hold_offer12 got valid=%b idx=%0d exp 1/12", grant_valid, grant_idx); end
    step();
    total++; if (grant_valid !== 1'b0 || pending !== 16'h0) begin bad++; $display("FAIL hold_accept12 got valid=%b pend=%h exp 0/0000", grant_valid, pending); end
    req_in = '0; grant_ready = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    enable = 1'b1; mask = '0; grant_ready = 1'b0;
    req_in = 16'h0020;
    step();
    req_in = '0;
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd5) begin bad++; $display("FAIL ovf_offer got valid=%b idx=%0d exp 1/5", grant_valid, grant_idx); end
    req_in = 16'h0020;
    step();
    total++; if (overflow !== 1'b1 || pending !== 16'h0020) begin bad++; $display("FAIL ovf_pulse got ovf=%b pend=%h exp 1/0020", overflow, pending); end
    step();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
    grant_ready = 1'b1;
    step();
    total++; if (grant_valid !== 1'b0 || pending !== 16'h0) begin bad++; $display("FAIL ovf_accept got valid=%b pend=%h exp 0/0000", grant_valid, pending); end
    step();
    total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL ovf_merged got valid=%b exp=0", grant_valid); end
    // Re-edge coincident with acceptance
    req_in = '0; grant_ready = 1'b0;
    step();
    req_in = 16'h0020;
    step();
    req_in = '0;
    step();
    grant_ready = 1'b1; req_in = 16'h0020;
    step();
    total++; if (overflow !== 1'b0 || pending !== 16'h0020 || grant_valid !== 1'b0) begin bad++; $display("FAIL ovf_coincident got ovf=%b pend=%h valid=%b exp 0/0020/0", overflow, pending, grant_valid); end
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd5) begin bad++; $display("FAIL ovf_regrant got valid=%b idx=%0d exp 1/5", grant_valid, grant_idx); end
    step();
    total++; if (grant_valid !== 1'b0 || pending !== 16'h0) begin bad++; $display("FAIL ovf_regrant_done got valid=%b pend=%h exp 0/0000", grant_valid, pending); end
    req_in = '0; grant_ready = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    enable = 1'b1; mask = '0; grant_ready = 1'b0;
    req_in = 16'h0200;
    step();
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd9) begin bad++; $display("FAIL arst_offer9 got valid=%b idx=%0d exp 1/9", grant_valid, grant_idx); end
    req_in = 16'h0004;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || pending !== 16'h0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL arst_clear got valid=%b idx=%0d pend=%h ovf=%b exp all 0", grant_valid, grant_idx, pending, overflow);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    total++; if (pending !== 16'h0004 || grant_valid !== 1'b0) begin bad++; $display("FAIL arst_level_edge got pend=%h valid=%b exp 0004/0", pending, grant_valid); end
    step();
    total++; if (grant_valid !== 1'b1 || grant_idx !== 4'd2) begin bad++; $display("FAIL arst_offer2 got valid=%b idx=%0d exp 1/2", grant_valid, grant_idx); end
    grant_ready = 1'b1;
    step();
    req_in = '0; grant_ready = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      enable      = ($urandom_range(0, 7) != 0);
      req_in      = req_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      mask        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      grant_ready = 1'($urandom_range(0, 1));
      step();
      total++; if (grant_valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, grant_valid, m_valid); end
      total++; if (grant_idx !== m_idx) begin bad++; $display("FAIL rnd_idx cyc=%0d got=%0d exp=%0d", c, grant_idx, m_idx); end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pending cyc=%0d got=%h exp=%h", c, pending, m_pend); end
      total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow cyc=%0d got=%b exp=%b", c, overflow, m_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_hold();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
